// File: rtl/button_cmd_sched_pkg.sv
// ---------------------------------------------------------------------------
// button_cmd_sched_pkg
// Shared definitions for the button command front-end and its consumer
// (the Temporizer decodes the same command codes).
//   - CMD_* : 3-bit command codes carried on cmd_code
//   - BTN_* : bit positions of the buttons in the internal level vector
//   - sched_state_t : repeat FSM state encoding
//   - cmd_entry_t   : one buffered command {code, repeat flag}
// ---------------------------------------------------------------------------
package button_cmd_sched_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_DOWN   = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_ACTION = 3'd5;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_ACTION = 4;
    localparam int BTN_N      = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [2:0] code;
        logic       rpt;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/button_cmd_sched_cmd_fifo2.sv
// ---------------------------------------------------------------------------
// cmd_fifo2
// Two-entry synchronous FIFO holding command entries. Slot 0 is always the
// head; a pop shifts slot 1 forward. Push and pop in the same cycle are both
// honoured, so a full FIFO accepts a push when it is also being popped.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write push_data_i (ignored when full and not popping)
//   push_data_i   : entry to write
//   pop_i         : remove the head (ignored when empty)
//   head_o        : head entry, all zeros when empty
//   full_o        : two entries held
//   empty_o       : no entries held
// ---------------------------------------------------------------------------
module cmd_fifo2
    import button_cmd_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [ENTRY_W-1:0] slot0_q;
    logic [ENTRY_W-1:0] slot1_q;
    logic [1:0]         count_q;
    logic               pop_ok;
    logic               push_ok;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = empty_o ? '0 : slot0_q;

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // NOTE: every flop is written with <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two slots are tiny, so they are reset along with the
            // count; this keeps the head deterministic in simulation.
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= push_data_i;
                    else                 slot1_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind the
                    // surviving one (or becomes the head if none survives).
                    if (count_q == 2'd1) begin
                        slot0_q <= push_data_i;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/button_cmd_sched.sv
// ---------------------------------------------------------------------------
// button_cmd_sched
// Front-end between the debouncer and the Temporizer. Turns five debounced
// button levels into single prioritised command events, auto-repeats
// up/down while held, and delivers commands over valid/ready through a
// two-entry buffer.
//   clk, rst      : clock, synchronous active-high reset
//   btn_*         : debounced button levels
//   cmd_valid     : head command present
//   cmd_code      : head command code (CMD_* in the package), 0 when empty
//   cmd_repeat    : head command is an auto-repeat
//   cmd_ready     : consumer takes the head this cycle
//   overflow      : sticky, a press was dropped because the buffer was full
//   overflow_clr  : clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module button_cmd_sched
    import button_cmd_sched_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_action,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_repeat,
    input  logic       cmd_ready,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Input stage: current and previous registered levels.
    logic [BTN_N-1:0] btn_q;
    logic [BTN_N-1:0] btn_prev_q;
    logic [BTN_N-1:0] rise;

    // Repeat FSM.
    sched_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       owner_q;

    // Event and buffer signals.
    logic       press_evt;
    logic [2:0] press_code;
    logic       owner_level;
    logic       period_done;
    logic       repeat_evt;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop_press;
    cmd_entry_t push_entry;
    cmd_entry_t head_entry;
    logic       overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q      <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_q      <= {btn_action, btn_right, btn_left, btn_down, btn_up};
            btn_prev_q <= btn_q;
        end
    end

    assign rise = btn_q & ~btn_prev_q;

    // Priority encoder: action > up > down > left > right. Lower-priority
    // rises in the same cycle are discarded.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        press_code = CMD_NONE;
        if      (rise[BTN_ACTION]) press_code = CMD_ACTION;
        else if (rise[BTN_UP])     press_code = CMD_UP;
        else if (rise[BTN_DOWN])   press_code = CMD_DOWN;
        else if (rise[BTN_LEFT])   press_code = CMD_LEFT;
        else if (rise[BTN_RIGHT])  press_code = CMD_RIGHT;
    end

    assign press_evt = (press_code != CMD_NONE);

    // A repeat fires at the end of a hold/repeat period while the owner is
    // still held; a simultaneous press preempts it.
    always_comb begin
        owner_level = (owner_q == CMD_UP) ? btn_q[BTN_UP] : btn_q[BTN_DOWN];
        period_done = ((state_q == ST_HOLD)   && (cnt_q == HOLD_LAST)) ||
                      ((state_q == ST_REPEAT) && (cnt_q == REPEAT_LAST));
        repeat_evt  = (state_q != ST_IDLE) && owner_level && period_done && !press_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= CMD_NONE;
        end else if (press_evt) begin
            cnt_q <= '0;
            if (press_code == CMD_UP || press_code == CMD_DOWN) begin
                state_q <= ST_HOLD;
                owner_q <= press_code;
            end else begin
                state_q <= ST_IDLE;
                owner_q <= CMD_NONE;
            end
        end else begin
            case (state_q)
                ST_HOLD, ST_REPEAT: begin
                    if (!owner_level) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        owner_q <= CMD_NONE;
                    end else if (period_done) begin
                        state_q <= ST_REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Presses may use a slot freed by a same-cycle pop; repeats only enter an
    // empty buffer so a slow consumer never builds a repeat backlog.
    assign fifo_pop   = cmd_valid && cmd_ready;
    assign drop_press = press_evt && fifo_full && !fifo_pop;
    assign fifo_push  = press_evt ? !drop_press : (repeat_evt && fifo_empty);

    always_comb begin
        push_entry.code = press_evt ? press_code : owner_q;
        push_entry.rpt  = !press_evt;
    end

    cmd_fifo2 u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)               overflow_q <= 1'b0;
        else if (drop_press)   overflow_q <= 1'b1;
        else if (overflow_clr) overflow_q <= 1'b0;
    end

    assign cmd_valid  = !fifo_empty;
    assign cmd_code   = head_entry.code;
    assign cmd_repeat = head_entry.rpt;
    assign overflow   = overflow_q;

endmodule
